// File: rtl/demul_if.sv
// Bundle of the demul bit-steering inputs and assembled-byte outputs.
// master drives the serial bit side, slave is the demultiplexer itself.
// No flow control: one bit is accepted on every cycle that we is high.
interface demul_if;
   logic       d;
   logic [3:0] sel;
   logic       we;
   logic       clr;
   logic [7:0] data_out;
   logic [7:0] written;
   logic [2:0] ptr;
   logic [7:0] byte_out;
   logic       byte_valid;

   modport master (
      output d, sel, we, clr,
      input  data_out, written, ptr, byte_out, byte_valid
   );

   modport slave (
      input  d, sel, we, clr,
      output data_out, written, ptr, byte_out, byte_valid
   );
endinterface

// File: rtl/demul.sv
// Registered 1-to-8 bit demultiplexer that rebuilds a byte from a serial bit path.
// Latency: writes visible 1 cycle after we; completed byte + 1-cycle valid pulse 1 cycle after 8th bit.
// Backpressure: none; one bit accepted every cycle we is high, clr abandons the partial byte.
module demul (
   input  logic        clk,
   input  logic        rst,
   demul_if.slave      bus
);

   logic [7:0] r_data_out;
   logic [7:0] r_written;
   logic [2:0] r_ptr;
   logic [7:0] r_byte_out;
   logic       r_byte_valid;

   logic [2:0] w_idx;
   logic [7:0] w_onehot;
   logic [7:0] w_next_data;
   logic       w_write;
   logic       w_complete;

   // Target index: auto pointer when sel[3] is set, explicit index otherwise.
   assign w_idx       = bus.sel[3] ? r_ptr : bus.sel[2:0];
   assign w_onehot    = 8'd1 << w_idx;
   assign w_next_data = (r_data_out & ~w_onehot) | (bus.d ? w_onehot : 8'h00);
   // clr wins over we, so a write only counts when clr is low.
   assign w_write     = bus.we && !bus.clr;
   // Completion is the write that fills the last empty position of the mask;
   // rewriting an already-set position can never complete.
   assign w_complete  = w_write && ((r_written | w_onehot) == 8'hFF);

   // Storage, mask, pointer and completed-byte registers with pulse generation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_out   <= 8'h00;
         r_written    <= 8'h00;
         r_ptr        <= 3'd0;
         r_byte_out   <= 8'h00;
         r_byte_valid <= 1'b0;
      end else begin
         r_byte_valid <= 1'b0;
         if (bus.clr) begin
            r_written <= 8'h00;
            r_ptr     <= 3'd0;
         end else if (bus.we) begin
            r_data_out <= w_next_data;
            if (w_complete) begin
               r_byte_out   <= w_next_data;
               r_byte_valid <= 1'b1;
               r_written    <= 8'h00;
               r_ptr        <= 3'd0;
            end else begin
               r_written <= r_written | w_onehot;
               if (bus.sel[3]) begin
                  r_ptr <= r_ptr + 3'd1;
               end
            end
         end
      end
   end

   assign bus.data_out   = r_data_out;
   assign bus.written    = r_written;
   assign bus.ptr        = r_ptr;
   assign bus.byte_out   = r_byte_out;
   assign bus.byte_valid = r_byte_valid;

endmodule

// File: tb/tb_demul.sv
// Directed testbench for demul with hand-computed expected values.
module tb_demul;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   demul_if bus ();

   demul dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic dv, input logic [3:0] s);
      bus.we  = 1'b1;
      bus.clr = 1'b0;
      bus.d   = dv;
      bus.sel = s;
      step();
      bus.we  = 1'b0;
   endtask

   task automatic idle();
      bus.we  = 1'b0;
      bus.clr = 1'b0;
      step();
   endtask

   task automatic check_all(input string tag, input logic [7:0] dout, input logic [7:0] wm,
                            input logic [2:0] p, input logic [7:0] bo, input logic bv);
      check({tag, ".data_out"},   32'(bus.data_out),   32'(dout));
      check({tag, ".written"},    32'(bus.written),    32'(wm));
      check({tag, ".ptr"},        32'(bus.ptr),        32'(p));
      check({tag, ".byte_out"},   32'(bus.byte_out),   32'(bo));
      check({tag, ".byte_valid"}, 32'(bus.byte_valid), 32'(bv));
   endtask

   logic [7:0] auto_bits;
   logic [2:0] dir_idx [8];
   int         pulses;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      bus.d    = 1'b0;
      bus.sel  = 4'h0;
      bus.we   = 1'b0;
      bus.clr  = 1'b0;
      dir_idx  = '{3'd7, 3'd0, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};

      // Reset
      #1;
      step();
      step();
      rst = 1'b0;
      check_all("reset", 8'h00, 8'h00, 3'd0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle();
         check_all("reset_idle", 8'h00, 8'h00, 3'd0, 8'h00, 1'b0);
      end

      // Auto assembly, LSB first: 1,0,1,1,0,0,1,0 -> 8'h4D
      auto_bits = 8'b0100_1101;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         wr(auto_bits[i], 4'b1000);
         if (bus.byte_valid) pulses++;
         if (i == 6) begin
            check("auto_ptr7", 32'(bus.ptr), 32'd7);
            check("auto_mask7", 32'(bus.written), 32'h7F);
         end
      end
      check_all("auto_done", 8'h4D, 8'h00, 3'd0, 8'h4D, 1'b1);
      // Next assembly starts while byte_valid is high.
      wr(1'b1, 4'b1000);
      if (bus.byte_valid) pulses++;
      check("auto_pulses", 32'(pulses), 32'd1);
      check_all("auto_next", 8'h4D, 8'h01, 3'd1, 8'h4D, 1'b0);
      // clr with we=0 abandons the started byte.
      bus.clr = 1'b1;
      step();
      bus.clr = 1'b0;
      check_all("auto_clr", 8'h4D, 8'h00, 3'd0, 8'h4D, 1'b0);

      // Direct, out of order, all ones
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         wr(1'b1, {1'b0, dir_idx[i]});
         if (bus.byte_valid) pulses++;
         if (i < 7) check("dir_ptr_hold", 32'(bus.ptr), 32'd0);
      end
      check("dir_pulses", 32'(pulses), 32'd1);
      check_all("dir_done", 8'hFF, 8'h00, 3'd0, 8'hFF, 1'b1);
      idle();
      check("dir_pulse_end", 32'(bus.byte_valid), 32'd0);

      // Direct with overwrite of index 3 before the last write -> 8'hF7
      pulses = 0;
      for (int i = 0; i < 7; i++) begin
         wr(1'b1, {1'b0, dir_idx[i]});
         if (bus.byte_valid) pulses++;
      end
      wr(1'b0, 4'b0011);
      if (bus.byte_valid) pulses++;
      check("rewr_mask", 32'(bus.written), 32'hEF);
      check("rewr_early", 32'(pulses), 32'd0);
      check("rewr_data", 32'(bus.data_out), 32'hF7);
      wr(1'b1, 4'b0100);
      check_all("rewr_done", 8'hF7, 8'h00, 3'd0, 8'hF7, 1'b1);

      // Clear mid-assembly with simultaneous we
      for (int i = 0; i < 5; i++) wr(1'b0, 4'b1000);
      check("clr_pre_mask", 32'(bus.written), 32'h1F);
      check("clr_pre_ptr", 32'(bus.ptr), 32'd5);
      bus.we  = 1'b1;
      bus.clr = 1'b1;
      bus.d   = 1'b1;
      bus.sel = 4'b1000;
      step();
      bus.we  = 1'b0;
      bus.clr = 1'b0;
      check_all("clr", 8'hE0, 8'h00, 3'd0, 8'hF7, 1'b0);
      for (int i = 0; i < 8; i++) wr(1'b1, 4'b1000);
      check_all("clr_refill", 8'hFF, 8'h00, 3'd0, 8'hFF, 1'b1);

      // Mixed mode: auto bits 0-3 = 1, direct bits 4-7 = 0 -> 8'h0F
      for (int i = 0; i < 4; i++) wr(1'b1, 4'b1000);
      for (int i = 4; i < 7; i++) wr(1'b0, 4'(i));
      check("mix_ptr_pre", 32'(bus.ptr), 32'd4);
      check("mix_mask_pre", 32'(bus.written), 32'h7F);
      wr(1'b0, 4'd7);
      check_all("mix_done", 8'h0F, 8'h00, 3'd0, 8'h0F, 1'b1);

      // Reset mid-assembly with we high
      for (int i = 0; i < 6; i++) wr(1'b1, 4'b1000);
      check("rst_pre_data", 32'(bus.data_out), 32'h3F);
      rst     = 1'b1;
      bus.we  = 1'b1;
      bus.d   = 1'b1;
      bus.sel = 4'b1000;
      step();
      rst    = 1'b0;
      bus.we = 1'b0;
      check_all("rst_mid", 8'h00, 8'h00, 3'd0, 8'h00, 1'b0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         wr(1'b0, 4'b1000);
         if (bus.byte_valid) pulses++;
      end
      check("rst_refill_pulses", 32'(pulses), 32'd1);
      check_all("rst_refill", 8'h00, 8'h00, 3'd0, 8'h00, 1'b1);
      idle();
      check("final_pulse_end", 32'(bus.byte_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
